// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: default widths, starvation counter
// width and FSM state encodings.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 3;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// The slave view is what the arbiter sees; master is the requester/memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_done, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_done, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  busy
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Priority select: data wins unless fetch has lost MAX_WAIT contested
// arbitrations in a row, in which case fetch wins.
module mem_arb_sel
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    input  logic fetch_granted,
    output logic sel_fetch
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;

    assign sel_fetch = if_req && (!d_req || (starve_cnt == SAT));

    // Only contested losses count; an uncontested data grant leaves the count alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fetch_granted) begin
            starve_cnt <= '0;
        end else if (arb_en && if_req && d_req && !sel_fetch && (starve_cnt != SAT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one
// single-outstanding memory interface with starvation-bounded data priority.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no access in flight; arbitrate any pending request
//   ST_FETCH | fetch access in flight; mem_en high until mem_ready
//   ST_DATA  | load/store access in flight; mem_en high until mem_ready
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_nx;

    logic              arb_en;
    logic              sel_fetch;
    logic              fetch_granted;

    logic              we_q;
    logic              if_gnt_q;
    logic              d_gnt_q;
    logic              if_done_q;
    logic              d_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign arb_en        = (state == ST_IDLE) && (bus.if_req || bus.d_req);
    assign fetch_granted = arb_en && sel_fetch;

    mem_arb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (bus.if_req),
        .d_req         (bus.d_req),
        .arb_en        (arb_en),
        .fetch_granted (fetch_granted),
        .sel_fetch     (sel_fetch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // mem_ready is only looked at in the access states, which is exactly when mem_en is high.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (arb_en) begin
                    state_nx = sel_fetch ? ST_FETCH : ST_DATA;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (bus.mem_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_gnt_q  <= 1'b0;
            d_gnt_q   <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;

            if (arb_en) begin
                if (sel_fetch) begin
                    if_gnt_q <= 1'b1;
                    addr_q   <= bus.if_addr;
                    we_q     <= 1'b0;
                end else begin
                    d_gnt_q  <= 1'b1;
                    addr_q   <= bus.d_addr;
                    wdata_q  <= bus.d_wdata;
                    we_q     <= bus.d_we;
                end
            end

            if ((state == ST_FETCH) && bus.mem_ready) begin
                if_done_q  <= 1'b1;
                if_rdata_q <= bus.mem_rdata;
            end

            // Stores complete without touching the load result register.
            if ((state == ST_DATA) && bus.mem_ready) begin
                d_done_q <= 1'b1;
                if (!we_q) begin
                    d_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = (state != ST_IDLE);
    assign bus.mem_we    = (state == ST_DATA) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width.
REQ-002 Parameter DATA_W, default 16: memory word width.
REQ-003 Parameter MAX_WAIT, default 3: consecutive lost arbitrations after which fetch wins; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 if_req  in  1  instruction-fetch request; held with if_addr until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  one-cycle pulse: fetch request accepted and latched.
REQ-009 if_done  out  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetched word; held until the next if_done.
REQ-011 d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  one-cycle pulse: data request accepted and latched.
REQ-016 d_done  out  1  one-cycle pulse: data access complete.
REQ-017 d_rdata  out  DATA_W  load result; updated only on load completion.
REQ-018 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-019 mem_addr, mem_wdata  out  ADDR_W, DATA_W  latched access address and data.
REQ-020 mem_rdata  in  DATA_W  read data; valid when mem_ready is high.
REQ-021 mem_ready  in  1  memory completes the access in any cycle it is high while mem_en is high.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states are IDLE, FETCH and DATA.
REQ-024 IDLE: if no request is pending, remain in IDLE with all strobes low.
REQ-025 IDLE with a request: on the next edge, enter FETCH or DATA and latch the winner's address, we and wdata into the mem_* registers.
REQ-026 The winner's gnt is high for exactly the first cycle of FETCH or DATA; mem_en is high in that cycle and stays high until mem_ready is sampled high.
REQ-027 Priority: data wins over fetch unless the starvation count equals MAX_WAIT, in which case fetch wins.
REQ-028 Starvation count: +1 on each arbitration where if_req and d_req are both high and data wins; saturates at MAX_WAIT; cleared on every fetch grant.
REQ-029 On mem_ready sampled high in FETCH or DATA, the next cycle has: mem_en = 0, the owner's done = 1, rdata registered (loads/fetches only), state = IDLE.
REQ-030 Minimum latency: request seen at edge 0 -> gnt in cycle 1 -> mem_ready in cycle 1 -> done in cycle 2; the next grant is no earlier than cycle 3.
REQ-031 mem_ready is ignored while mem_en is low.
REQ-032 A request dropped before its grant is withdrawn without side effects.
REQ-033 A request that stays high after its done is re-arbitrated as a new request.
REQ-034 A store completion leaves d_rdata unchanged.
REQ-035 mem_we equals the latched d_we in DATA and is 0 in FETCH.
REQ-036 There is no timeout: mem_en stays high indefinitely until mem_ready is sampled high.

Reset
REQ-037 rst_n low at an edge forces state IDLE, starvation count 0, and all outputs (including mem_addr, mem_wdata, if_rdata, d_rdata) to 0 from the next cycle.
REQ-038 Reset during an access aborts it: no done pulse, no rdata update, and mem_ready during reset is ignored.

Structure
REQ-039 State encodings (IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2) and default widths go in the shared constants.v.
REQ-040 The priority/starvation logic is one sub-module, mem_arb_sel, with inputs if_req, d_req, arb_en and fetch_granted, and output sel_fetch.

Verification
REQ-041 Single fetch: if_req, addr 0x10; mem_ready high 1 cycle after mem_en; mem_rdata 0xBEEF -> if_gnt in cycle 1, if_done in cycle 3, if_rdata = 0xBEEF.
REQ-042 Simultaneous if_req and d_req held high, MAX_WAIT = 3, zero-wait memory -> grant order D, D, D, F, D, D, D, F.
REQ-043 Store d_we = 1, addr 0x20, wdata 0x1234, mem_ready delayed 5 cycles -> mem_en high for 6 cycles with mem_we = 1 and the latched values held; d_done once; d_rdata unchanged.
REQ-044 Reset asserted 2 cycles into a DATA access -> no d_done; the cycle after the reset edge has mem_en = 0 and busy = 0; a later mem_ready is ignored.
REQ-045 if_req pulsed for 1 cycle while DATA is busy -> no if_gnt, no memory access, and starvation count unchanged.
